// File: rtl/dtanh_pipe_sched_if.sv
// Request/response bundle for the dtanh pipeline scheduler.
// master: requesters plus result consumer. slave: the scheduler.
interface dtanh_pipe_sched_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]    req_valid;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [31:0]         rsp_data;
  logic                rsp_ready;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/dtanh_pipe_sched.sv
// Round-robin scheduler sharing one fixed-latency dtanh pipeline among
// N_REQ requesters. Each issue is tagged with its requester ID in a shift
// register that advances together with the pipeline; a stalled response
// freezes both through pipe_en.
// Optional build macro DTANH_SCHED_STATS_EN adds stat_issued / stat_stall.
//
// state  | meaning
// IDLE   | no tag in flight
// ACTIVE | tags in flight, pipeline advancing
// HOLD   | result presented but not accepted, pipeline frozen
module dtanh_pipe_sched #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int LATENCY = 4
) (
  input  logic                clk,
  input  logic                reset,
  dtanh_pipe_sched_if.slave   bus,
  output logic [15:0]         pipe_din,
  output logic                pipe_en,
  input  logic [31:0]         pipe_dout,
`ifdef DTANH_SCHED_STATS_EN
  output logic [31:0]         stat_issued,
  output logic [31:0]         stat_stall,
`endif
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HOLD} state_t;

  state_t            state, state_nxt;
  logic [LATENCY-1:0] tag_v;
  logic [ID_W-1:0]   tag_id [LATENCY];
  logic [ID_W-1:0]   rr_ptr;
  logic              grant_hit;
  logic [ID_W-1:0]   grant_idx;
  logic [N_REQ-1:0]  grant_vec;
  logic              rsp_valid;
  logic              next_inflight;

  // Response side is the tail of the tag pipe; the data comes straight from the pipeline.
  assign rsp_valid     = tag_v[LATENCY-1] & ~reset;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = tag_id[LATENCY-1];
  assign bus.rsp_data  = pipe_dout;
  assign pipe_en       = ~reset & ~(rsp_valid & ~bus.rsp_ready);
  assign bus.req_ready = grant_vec;
  assign next_inflight = grant_hit | (|tag_v[LATENCY-2:0]);

  // Circular priority search starting at rr_ptr; suppressed while the pipe is frozen.
  always_comb begin
    int idx;
    grant_hit = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    pipe_din  = 16'h0000;
    idx       = 0;
    if (pipe_en) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (int'(rr_ptr) + k) % N_REQ;
        if (!grant_hit && bus.req_valid[idx]) begin
          grant_hit = 1'b1;
          grant_idx = ID_W'(idx);
        end
      end
    end
    if (grant_hit) begin
      grant_vec = N_REQ'(1) << grant_idx;
      pipe_din  = bus.req_data[16*int'(grant_idx) +: 16];
    end
  end

  // Round-robin pointer moves past the last grantee, wrapping at N_REQ-1.
  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (grant_hit)
      rr_ptr <= (int'(grant_idx) == N_REQ-1) ? '0 : grant_idx + 1'b1;
  end

  // Tag shift register advances in lockstep with the pipeline enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v <= '0;
      for (int k = 0; k < LATENCY; k++) tag_id[k] <= '0;
    end else if (pipe_en) begin
      tag_v     <= {tag_v[LATENCY-2:0], grant_hit};
      tag_id[0] <= grant_idx;
      for (int k = 1; k < LATENCY; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state and busy decode.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_hit) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        busy = 1'b1;
        if (rsp_valid && !bus.rsp_ready) state_nxt = S_HOLD;
        else if (!next_inflight)         state_nxt = S_IDLE;
      end
      S_HOLD: begin
        busy = 1'b1;
        if (bus.rsp_ready) state_nxt = S_ACTIVE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef DTANH_SCHED_STATS_EN
  // Issue and stall counters; free-running with natural 32-bit wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (grant_hit) stat_issued <= stat_issued + 32'd1;
      if (!pipe_en)  stat_stall  <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dtanh_pipe_sched.sv
// Bench for dtanh_pipe_sched: models the external 4-stage pipeline with a
// simple stand-in function, runs a cycle table, then backpressure and
// mid-flight reset sequences.
module tb_dtanh_pipe_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pipe_din;
  logic        pipe_en;
  logic [31:0] pipe_dout;
  logic        busy;
  logic [3:0]  rv;
  logic        rr;
  logic [15:0] d [4];
  logic [31:0] pstage [4];
  int          n_tests = 0;
  int          n_fail  = 0;
`ifdef DTANH_SCHED_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif

  always #5 clk = ~clk;

  dtanh_pipe_sched_if #(.N_REQ(4), .ID_W(2)) bus ();

  dtanh_pipe_sched #(.N_REQ(4), .ID_W(2), .LATENCY(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .pipe_din   (pipe_din),
    .pipe_en    (pipe_en),
    .pipe_dout  (pipe_dout),
`ifdef DTANH_SCHED_STATS_EN
    .stat_issued(stat_issued),
    .stat_stall (stat_stall),
`endif
    .busy       (busy)
  );

  assign bus.req_valid = rv;
  assign bus.rsp_ready = rr;
  assign bus.req_data  = {d[3], d[2], d[1], d[0]};
  assign pipe_dout     = pstage[3];

  // Stand-in for the dtanh pipeline: one known point, otherwise a reversible tag.
  function automatic logic [31:0] f(input logic [15:0] x);
    return (x == 16'h4200) ? 32'h322BCC77 : {~x, x};
  endfunction

  // External pipeline model: four enabled stages.
  always @(posedge clk) begin
    if (pipe_en) begin
      pstage[0] <= f(pipe_din);
      pstage[1] <= pstage[0];
      pstage[2] <= pstage[1];
      pstage[3] <= pstage[2];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    rv    = 4'hF;
    rr    = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_pipe_en",   pipe_en, 0);
    chk("rst_pipe_din",  pipe_din, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id",    bus.rsp_id, 0);
    chk("rst_busy",      busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    rv    = 4'h0;
  endtask

  typedef struct {
    logic [3:0] rv;
    logic       rr;
    logic [3:0] ready;
    logic       vld;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t tbl [23];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  exp_id_q [$];
    logic [31:0] exp_dat_q [$];
    logic [31:0] prev_dat;
    logic [1:0]  prev_id;
    logic [15:0] expd;
    bit          prev_stalled;
    bit          hs;
    int          gid, granted, got, stall;

    // single op, fairness, wrap: rr_ptr starts 0 after reset, rsp_ready held 1
    tbl[0]  = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};
    tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};
    tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1};
    tbl[4]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{4'b1111, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b1};
    tbl[8]  = '{4'b1111, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b1};
    tbl[9]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b1};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[14] = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 1'b0};
    tbl[15] = '{4'b1001, 1'b1, 4'b1000, 1'b0, 2'd0, 1'b1};
    tbl[16] = '{4'b1001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1};
    tbl[17] = '{4'b0001, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b1};
    tbl[18] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1};
    tbl[19] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1};
    tbl[20] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[21] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1};
    tbl[22] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};

    d[0] = 16'h4200; d[1] = 16'h3F80; d[2] = 16'hC040; d[3] = 16'h0001;
    do_reset();

    for (int i = 0; i < 23; i++) begin
      rv = tbl[i].rv;
      rr = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), bus.req_ready, tbl[i].ready);
      chk($sformatf("tbl%0d_valid", i), bus.rsp_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_busy", i),  busy, tbl[i].busy);
      chk($sformatf("tbl%0d_en", i),    pipe_en, !(tbl[i].vld && !tbl[i].rr));
      expd = (tbl[i].ready != 0) ? d[onehot_idx(tbl[i].ready)] : 16'h0000;
      chk($sformatf("tbl%0d_din", i),   pipe_din, expd);
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_id", i),   bus.rsp_id, tbl[i].id);
        chk($sformatf("tbl%0d_data", i), bus.rsp_data, f(d[tbl[i].id]));
      end
      @(posedge clk); #1;
    end

    // backpressure: 8 ops with random operands, stall 5 cycles on the 2nd result
    for (int i = 0; i < 4; i++) d[i] = 16'($urandom_range(0, 65535));
    do_reset();
    granted = 0; got = 0; stall = 0; prev_stalled = 0;
    prev_dat = '0; prev_id = '0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      rr = !(bus.rsp_valid && got == 1 && stall < 5);
      rv = (granted < 8) ? 4'hF : 4'h0;
      hs = 0;
      gid = 0;
      @(negedge clk);
      if (!rr) begin
        stall++;
        chk("bp_pipe_en", pipe_en, 0);
        chk("bp_no_grant", bus.req_ready, 0);
        if (prev_stalled) begin
          chk("bp_data_stable", bus.rsp_data, prev_dat);
          chk("bp_id_stable", bus.rsp_id, prev_id);
        end
        prev_dat = bus.rsp_data;
        prev_id  = bus.rsp_id;
        prev_stalled = 1;
      end else begin
        prev_stalled = 0;
      end
      if (bus.req_ready != 0) begin
        gid = onehot_idx(bus.req_ready);
        chk("bp_grant_order", gid, granted % 4);
        chk("bp_pipe_din", pipe_din, d[gid]);
        exp_id_q.push_back(2'(gid));
        exp_dat_q.push_back(f(d[gid]));
        granted++;
        hs = 1;
      end
      if (bus.rsp_valid && rr) begin
        if (exp_id_q.size() == 0) begin
          chk("bp_spurious_rsp", 1, 0);
        end else begin
          chk($sformatf("bp_rsp%0d_id", got), bus.rsp_id, exp_id_q.pop_front());
          chk($sformatf("bp_rsp%0d_data", got), bus.rsp_data, exp_dat_q.pop_front());
        end
        got++;
      end
      @(posedge clk); #1;
      if (hs) d[gid] = 16'($urandom_range(0, 65535));
    end
    chk("bp_delivered", got, 8);
    chk("bp_leftover", exp_id_q.size(), 0);
    chk("bp_stall_cycles", stall, 5);
`ifdef DTANH_SCHED_STATS_EN
    chk("stat_issued", stat_issued, 8);
    chk("stat_stall", stat_stall, 5);
`endif

    // reset mid-flight: issue 0,1,2 then reset; nothing may come out afterwards
    d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333; d[3] = 16'h4444;
    do_reset();
    rv = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("mf_grant%0d", i), bus.req_ready, 4'b0001 << i);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    rv    = 4'b0000;
    @(negedge clk);
    chk("mf_rst_valid", bus.rsp_valid, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("mf_post%0d_valid", i), bus.rsp_valid, 0);
      chk($sformatf("mf_post%0d_busy", i), busy, 0);
      @(posedge clk); #1;
    end
    rv = 4'hF;
    @(negedge clk);
    chk("mf_rr_ptr_zero", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    rv = 4'h0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
